harq_llr_burst_receiver: RTL and testbench

- HARQ-side receiver for the 96-bit LLR word stream produced by the rate-dematcher send FSM.
- Accepts contiguous valid bursts, one burst per user code block: 16 lanes x 6-bit LLRs per word, a per-word lane amount and a 4-bit user index.
- Writes each word into the per-user region of the HARQ buffer with lane byte-enables.
- Reports per-burst completion (user, LLR count) and error conditions to the HARQ controller.

---
 rtl/harq_llr_burst_receiver_if.sv | 37 +++
 rtl/harq_llr_burst_receiver.sv | 154 +++++++++++++++
 tb/tb_harq_llr_burst_receiver.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/harq_llr_burst_receiver_if.sv
// LLR burst stream from the rate dematcher and the HARQ buffer write / status side.
// slave = receiver view, master = stream source / controller view.
interface harq_llr_burst_receiver_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              i_rdm_slot_start;
  logic [95:0]       Data_SEND_TO_HARQ;
  logic              Data_SEND_TO_HARQ_VALID;
  logic [3:0]        Data_SEND_TO_HARQ_AMOUNT;
  logic [3:0]        Data_SEND_TO_HARQ_USER_INDEX;
  logic              o_harq_wr_en;
  logic [ADDR_W-1:0] o_harq_wr_addr;
  logic [95:0]       o_harq_wr_data;
  logic [15:0]       o_harq_wr_lane_en;
  logic              o_burst_done;
  logic [3:0]        o_burst_user;
  logic [15:0]       o_burst_llr_count;
  logic              o_busy;
  logic              o_err_overflow;
  logic              o_err_user_change;

  modport slave (
    input  i_rdm_slot_start, Data_SEND_TO_HARQ, Data_SEND_TO_HARQ_VALID,
           Data_SEND_TO_HARQ_AMOUNT, Data_SEND_TO_HARQ_USER_INDEX,
    output o_harq_wr_en, o_harq_wr_addr, o_harq_wr_data, o_harq_wr_lane_en,
           o_burst_done, o_burst_user, o_burst_llr_count, o_busy,
           o_err_overflow, o_err_user_change
  );

  modport master (
    output i_rdm_slot_start, Data_SEND_TO_HARQ, Data_SEND_TO_HARQ_VALID,
           Data_SEND_TO_HARQ_AMOUNT, Data_SEND_TO_HARQ_USER_INDEX,
    input  o_harq_wr_en, o_harq_wr_addr, o_harq_wr_data, o_harq_wr_lane_en,
           o_burst_done, o_burst_user, o_burst_llr_count, o_busy,
           o_err_overflow, o_err_user_change
  );
endinterface

// File: rtl/harq_llr_burst_receiver.sv
// HARQ-side LLR burst receiver: writes each word into its user's buffer region and reports bursts.
// Optional macro HARQ_ZERO_PAD_EN: zero unused lanes and write the full word.
module harq_llr_burst_receiver #(
  parameter int unsigned USER_NUM       = 16,
  parameter int unsigned WORDS_PER_USER = 2048,
  parameter int unsigned ADDR_W         = 15
) (
  input logic                      i_core_clk,
  input logic                      i_rx_rst,
  harq_llr_burst_receiver_if.slave rx
);

  localparam int unsigned OFF_W  = $clog2(WORDS_PER_USER);
  localparam int unsigned CNT_W  = OFF_W + 1;
  localparam int unsigned USER_W = $clog2(USER_NUM);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_USER);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RECV = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t state, state_nxt;

  logic [USER_W-1:0] cur_user;
  logic [CNT_W-1:0]  word_cnt;
  logic [15:0]       llr_acc;

  logic              valid;
  logic [3:0]        amount;
  logic [USER_W-1:0] in_user;

  logic              first;
  logic              over;
  logic              user_chg;
  logic [USER_W-1:0] wr_user;
  logic [CNT_W-1:0]  wr_cnt;
  logic [15:0]       acc_base;
  logic [16:0]       acc_sum;
  logic [15:0]       acc_nxt;
  logic [15:0]       lane_mask;
  logic [95:0]       data_out;
  logic [15:0]       lane_out;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [95:0]       wr_data_q;
  logic [15:0]       wr_lane_q;
  logic [3:0]        burst_user_q;
  logic [15:0]       burst_cnt_q;
  logic              err_ovf_q;
  logic              err_usr_q;

  assign valid   = rx.Data_SEND_TO_HARQ_VALID;
  assign amount  = rx.Data_SEND_TO_HARQ_AMOUNT;
  assign in_user = rx.Data_SEND_TO_HARQ_USER_INDEX[USER_W-1:0];

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid)  state_nxt = RECV;
      RECV:    if (!valid) state_nxt = DONE;
      DONE:    state_nxt = valid ? RECV : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A valid word outside RECV (IDLE or DONE) always opens a new burst
  always_comb begin
    first    = valid && (state != RECV);
    wr_user  = first ? in_user : cur_user;
    wr_cnt   = first ? '0 : word_cnt;
    over     = valid && (wr_cnt == CNT_FULL);
    user_chg = valid && !first && (in_user != cur_user);
    acc_base = first ? '0 : llr_acc;
    acc_sum  = {1'b0, acc_base} + {13'd0, amount} + 17'd1;
    acc_nxt  = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
  end

  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      lane_mask[i] = (4'(i) <= amount);
    end
  end

`ifdef HARQ_ZERO_PAD_EN
  always_comb begin
    data_out = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      data_out[6*i +: 6] = lane_mask[i] ? rx.Data_SEND_TO_HARQ[6*i +: 6] : 6'd0;
    end
    lane_out = '1;
  end
`else
  always_comb begin
    data_out = rx.Data_SEND_TO_HARQ;
    lane_out = lane_mask;
  end
`endif

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      cur_user     <= '0;
      word_cnt     <= '0;
      llr_acc      <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_lane_q    <= '0;
      burst_user_q <= '0;
      burst_cnt_q  <= '0;
      err_ovf_q    <= 1'b0;
      err_usr_q    <= 1'b0;
    end else begin
      wr_en_q <= valid && !over;
      if (valid) begin
        cur_user <= wr_user;
        // Once the region is full the count and LLR total freeze for the rest of the burst
        if (!over) begin
          word_cnt  <= wr_cnt + 1'b1;
          llr_acc   <= acc_nxt;
          wr_addr_q <= ADDR_W'({wr_user, wr_cnt[OFF_W-1:0]});
          wr_data_q <= data_out;
          wr_lane_q <= lane_out;
        end
      end
      if (state == RECV && !valid) begin
        burst_user_q <= 4'(cur_user);
        burst_cnt_q  <= llr_acc;
      end
      err_ovf_q <= over     || (err_ovf_q && !rx.i_rdm_slot_start);
      err_usr_q <= user_chg || (err_usr_q && !rx.i_rdm_slot_start);
    end
  end

  assign rx.o_harq_wr_en      = wr_en_q;
  assign rx.o_harq_wr_addr    = wr_addr_q;
  assign rx.o_harq_wr_data    = wr_data_q;
  assign rx.o_harq_wr_lane_en = wr_lane_q;
  assign rx.o_burst_done      = (state == DONE);
  assign rx.o_burst_user      = burst_user_q;
  assign rx.o_burst_llr_count = burst_cnt_q;
  assign rx.o_busy            = (state == RECV);
  assign rx.o_err_overflow    = err_ovf_q;
  assign rx.o_err_user_change = err_usr_q;

endmodule

// File: tb/tb_harq_llr_burst_receiver.sv
// Directed self-checking bench for harq_llr_burst_receiver (honours HARQ_ZERO_PAD_EN if defined).
module tb_harq_llr_burst_receiver;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  harq_llr_burst_receiver_if #(.ADDR_W(15)) bus ();

  harq_llr_burst_receiver #(
    .USER_NUM      (16),
    .WORDS_PER_USER(2048),
    .ADDR_W        (15)
  ) dut (
    .i_core_clk(clk),
    .i_rx_rst  (rst),
    .rx        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic v, input logic [3:0] amt, input logic [3:0] usr,
                     input logic [95:0] d);
    bus.Data_SEND_TO_HARQ_VALID      = v;
    bus.Data_SEND_TO_HARQ_AMOUNT     = amt;
    bus.Data_SEND_TO_HARQ_USER_INDEX = usr;
    bus.Data_SEND_TO_HARQ            = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] exp_data(input logic [95:0] d, input logic [3:0] amt);
    logic [95:0] r;
    r = d;
`ifdef HARQ_ZERO_PAD_EN
    for (int i = 0; i < 16; i++) if (i > int'(amt)) r[6*i +: 6] = 6'd0;
`endif
    return r;
  endfunction

  function automatic logic [15:0] exp_lane(input logic [3:0] amt);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (i <= int'(amt)) r[i] = 1'b1;
`ifdef HARQ_ZERO_PAD_EN
    r = 16'hFFFF;
`endif
    return r;
  endfunction

  logic [95:0] d0, d1, d2, dall;

  initial begin
    checks   = 0;
    failures = 0;
    d0   = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
    d1   = 96'hA5A5_A5A5_5A5A_5A5A_C3C3_C3C3;
    d2   = 96'hFFFF_0000_FFFF_0000_1234_5678;
    dall = '1;
    bus.i_rdm_slot_start = 1'b0;
    put(1'b0, 4'd0, 4'd0, '0);
    rst = 1'b1;
    #2;
    chk("rst_wr_en", 96'(bus.o_harq_wr_en), 96'd0);
    chk("rst_addr", 96'(bus.o_harq_wr_addr), 96'd0);
    chk("rst_done", 96'(bus.o_burst_done), 96'd0);
    chk("rst_busy", 96'(bus.o_busy), 96'd0);
    chk("rst_lane", 96'(bus.o_harq_wr_lane_en), 96'd0);
    tick; tick;
    rst = 1'b0;
    tick;

    // 3-word burst, user 5, amounts 15,15,7
    put(1'b1, 4'd15, 4'd5, d0); tick;
    chk("b1_w0_en", 96'(bus.o_harq_wr_en), 96'd1);
    chk("b1_w0_addr", 96'(bus.o_harq_wr_addr), 96'd10240);
    chk("b1_w0_data", bus.o_harq_wr_data, exp_data(d0, 4'd15));
    chk("b1_w0_lane", 96'(bus.o_harq_wr_lane_en), 96'(exp_lane(4'd15)));
    chk("b1_busy", 96'(bus.o_busy), 96'd1);
    put(1'b1, 4'd15, 4'd5, d1); tick;
    chk("b1_w1_addr", 96'(bus.o_harq_wr_addr), 96'd10241);
    put(1'b1, 4'd7, 4'd5, d2); tick;
    chk("b1_w2_addr", 96'(bus.o_harq_wr_addr), 96'd10242);
    chk("b1_w2_data", bus.o_harq_wr_data, exp_data(d2, 4'd7));
    chk("b1_w2_lane", 96'(bus.o_harq_wr_lane_en), 96'(exp_lane(4'd7)));
    chk("b1_w2_done", 96'(bus.o_burst_done), 96'd0);
    put(1'b0, 4'd0, 4'd0, '0); tick;
    chk("b1_end_en", 96'(bus.o_harq_wr_en), 96'd0);
    chk("b1_done", 96'(bus.o_burst_done), 96'd1);
    chk("b1_user", 96'(bus.o_burst_user), 96'd5);
    chk("b1_count", 96'(bus.o_burst_llr_count), 96'd40);
    chk("b1_done_busy", 96'(bus.o_busy), 96'd0);
    chk("b1_addr_hold", 96'(bus.o_harq_wr_addr), 96'd10242);
    tick;
    chk("b1_done_1cyc", 96'(bus.o_burst_done), 96'd0);
    chk("b1_user_hold", 96'(bus.o_burst_user), 96'd5);

    // single-word burst, user 0, amount 0
    put(1'b1, 4'd0, 4'd0, dall); tick;
    chk("b2_addr", 96'(bus.o_harq_wr_addr), 96'd0);
    chk("b2_data", bus.o_harq_wr_data, exp_data(dall, 4'd0));
    chk("b2_lane", 96'(bus.o_harq_wr_lane_en), 96'(exp_lane(4'd0)));
    put(1'b0, 4'd0, 4'd0, '0); tick;
    chk("b2_done", 96'(bus.o_burst_done), 96'd1);
    chk("b2_count", 96'(bus.o_burst_llr_count), 96'd1);
    chk("b2_user", 96'(bus.o_burst_user), 96'd0);
    tick;

    // back-to-back: user 2 burst, new user 9 burst starts in the DONE cycle
    put(1'b1, 4'd3, 4'd2, d0); tick;
    put(1'b1, 4'd3, 4'd2, d1); tick;
    put(1'b0, 4'd0, 4'd0, '0); tick;
    chk("b3_done", 96'(bus.o_burst_done), 96'd1);
    chk("b3_count", 96'(bus.o_burst_llr_count), 96'd8);
    chk("b3_user", 96'(bus.o_burst_user), 96'd2);
    put(1'b1, 4'd1, 4'd9, d2); tick;
    chk("b4_w0_en", 96'(bus.o_harq_wr_en), 96'd1);
    chk("b4_w0_addr", 96'(bus.o_harq_wr_addr), 96'd18432);
    chk("b4_w0_lane", 96'(bus.o_harq_wr_lane_en), 96'(exp_lane(4'd1)));
    chk("b4_w0_done", 96'(bus.o_burst_done), 96'd0);
    chk("b4_busy", 96'(bus.o_busy), 96'd1);
    put(1'b1, 4'd0, 4'd9, d0); tick;
    chk("b4_w1_addr", 96'(bus.o_harq_wr_addr), 96'd18433);
    put(1'b0, 4'd0, 4'd0, '0); tick;
    chk("b4_done", 96'(bus.o_burst_done), 96'd1);
    chk("b4_count", 96'(bus.o_burst_llr_count), 96'd3);
    chk("b4_user", 96'(bus.o_burst_user), 96'd9);
    chk("b4_no_err", 96'(bus.o_err_user_change), 96'd0);
    tick;

    // 2049-word burst to user 1: last word overflows
    for (int i = 0; i < 2049; i++) begin
      put(1'b1, 4'd15, 4'd1, 96'(i)); tick;
      if (i == 0) chk("ovf_first_addr", 96'(bus.o_harq_wr_addr), 96'd2048);
      if (i == 2047) begin
        chk("ovf_last_addr", 96'(bus.o_harq_wr_addr), 96'd4095);
        chk("ovf_last_en", 96'(bus.o_harq_wr_en), 96'd1);
        chk("ovf_flag_pre", 96'(bus.o_err_overflow), 96'd0);
      end
      if (i == 2048) begin
        chk("ovf_no_write", 96'(bus.o_harq_wr_en), 96'd0);
        chk("ovf_addr_hold", 96'(bus.o_harq_wr_addr), 96'd4095);
        chk("ovf_flag", 96'(bus.o_err_overflow), 96'd1);
      end
    end
    put(1'b0, 4'd0, 4'd0, '0); tick;
    chk("ovf_done", 96'(bus.o_burst_done), 96'd1);
    chk("ovf_count", 96'(bus.o_burst_llr_count), 96'd32768);
    chk("ovf_sticky", 96'(bus.o_err_overflow), 96'd1);
    bus.i_rdm_slot_start = 1'b1; tick;
    bus.i_rdm_slot_start = 1'b0;
    chk("ovf_clear", 96'(bus.o_err_overflow), 96'd0);
    tick;

    // user changes 3 -> 4 on the second word
    put(1'b1, 4'd15, 4'd3, d0); tick;
    chk("uc_flag_pre", 96'(bus.o_err_user_change), 96'd0);
    put(1'b1, 4'd15, 4'd4, d1); tick;
    chk("uc_addr", 96'(bus.o_harq_wr_addr), 96'd6145);
    chk("uc_flag", 96'(bus.o_err_user_change), 96'd1);
    put(1'b0, 4'd0, 4'd0, '0); tick;
    chk("uc_done_user", 96'(bus.o_burst_user), 96'd3);
    chk("uc_count", 96'(bus.o_burst_llr_count), 96'd32);
    bus.i_rdm_slot_start = 1'b1; tick;
    bus.i_rdm_slot_start = 1'b0;
    chk("uc_clear", 96'(bus.o_err_user_change), 96'd0);
    tick;

    // reset asserted mid-burst
    put(1'b1, 4'd5, 4'd6, d0); tick;
    put(1'b1, 4'd5, 4'd6, d1); tick;
    chk("mr_busy_pre", 96'(bus.o_busy), 96'd1);
    rst = 1'b1;
    #1;
    chk("mr_wr_en", 96'(bus.o_harq_wr_en), 96'd0);
    chk("mr_addr", 96'(bus.o_harq_wr_addr), 96'd0);
    chk("mr_busy", 96'(bus.o_busy), 96'd0);
    chk("mr_count", 96'(bus.o_burst_llr_count), 96'd0);
    chk("mr_user", 96'(bus.o_burst_user), 96'd0);
    put(1'b0, 4'd0, 4'd0, '0);
    tick;
    rst = 1'b0;
    tick;
    chk("mr_no_done", 96'(bus.o_burst_done), 96'd0);
    put(1'b1, 4'd2, 4'd6, d2); tick;
    chk("mr_new_addr", 96'(bus.o_harq_wr_addr), 96'd12288);
    put(1'b0, 4'd0, 4'd0, '0); tick;
    chk("mr_new_done", 96'(bus.o_burst_done), 96'd1);
    chk("mr_new_count", 96'(bus.o_burst_llr_count), 96'd3);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
